complete_bus_arbiter: RTL and testbench

- Sits between the three functional units (FU1–FU3) and the single result/wakeup bus.
- Consumes the results the FUs produce from reservation-station issues, with one small FIFO per FU.
- Grants one result per cycle round-robin and drives the registered wakeup broadcast.
- The reservation station and rename logic use the broadcast tag/value; the ROB uses the completion number.

---
 rtl/complete_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_complete_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complete_bus_arbiter.sv
// Result/wakeup bus arbiter: one small FIFO per functional unit, round-robin
// grant of one head per cycle, registered broadcast of tag/value/ROB index.
module complete_bus_arbiter #(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              fu1_valid,
  input  logic [TAG_W-1:0]  fu1_tag,
  input  logic [DATA_W-1:0] fu1_val,
  input  logic [ROB_W-1:0]  fu1_rob,
  output logic              fu1_accept,
  input  logic              fu2_valid,
  input  logic [TAG_W-1:0]  fu2_tag,
  input  logic [DATA_W-1:0] fu2_val,
  input  logic [ROB_W-1:0]  fu2_rob,
  output logic              fu2_accept,
  input  logic              fu3_valid,
  input  logic [TAG_W-1:0]  fu3_tag,
  input  logic [DATA_W-1:0] fu3_val,
  input  logic [ROB_W-1:0]  fu3_rob,
  output logic              fu3_accept,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wakeup_tag,
  output logic [DATA_W-1:0] wakeup_val,
  output logic [ROB_W-1:0]  complete_rob,
  output logic [1:0]        wb_src
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [2:0]        in_valid;
  logic [TAG_W-1:0]  in_tag [3];
  logic [DATA_W-1:0] in_val [3];
  logic [ROB_W-1:0]  in_rob [3];

  logic [TAG_W-1:0]  tag_mem [3][DEPTH];
  logic [DATA_W-1:0] val_mem [3][DEPTH];
  logic [ROB_W-1:0]  rob_mem [3][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [3];
  logic [PTR_W-1:0]  rd_ptr [3];
  logic [CNT_W-1:0]  count [3];

  logic [2:0] accept, nonempty, enq, deq;
  logic       grant_hit;
  logic [1:0] grant_idx, cand, last_grant;

  assign in_valid  = {fu3_valid, fu2_valid, fu1_valid};
  assign in_tag[0] = fu1_tag;
  assign in_tag[1] = fu2_tag;
  assign in_tag[2] = fu3_tag;
  assign in_val[0] = fu1_val;
  assign in_val[1] = fu2_val;
  assign in_val[2] = fu3_val;
  assign in_rob[0] = fu1_rob;
  assign in_rob[1] = fu2_rob;
  assign in_rob[2] = fu3_rob;

  // Handshake: a result transfers at the edge iff fuN_valid && fuN_accept;
  // accept comes from the registered count only, so the FU holds data while it is low.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      accept[i]   = (count[i] != CNT_W'(DEPTH));
      nonempty[i] = (count[i] != '0);
      enq[i]      = in_valid[i] && accept[i];
    end
  end

  assign fu1_accept = accept[0];
  assign fu2_accept = accept[1];
  assign fu3_accept = accept[2];

  // last_grant holds FU number 1..3; as a 0-based index it is exactly the next FU in turn.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 3; k++) begin
      cand = 2'((32'(last_grant) + k) % 3);
      if (!grant_hit && nonempty[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
    end
    deq = '0;
    if (grant_hit) deq[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset || flush) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end else begin
        if (enq[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (deq[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({enq[i], deq[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (enq[i] && !reset && !flush) begin
        tag_mem[i][wr_ptr[i]] <= in_tag[i];
        val_mem[i][wr_ptr[i]] <= in_val[i];
        rob_mem[i][wr_ptr[i]] <= in_rob[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wakeup_tag   <= '0;
      wakeup_val   <= '0;
      complete_rob <= '0;
      wb_src       <= 2'd0;
      last_grant   <= 2'd3;
    end else if (flush || !grant_hit) begin
      wb_valid     <= 1'b0;
      wakeup_tag   <= '0;
      wakeup_val   <= '0;
      complete_rob <= '0;
      wb_src       <= 2'd0;
    end else begin
      wb_valid     <= 1'b1;
      wakeup_tag   <= tag_mem[grant_idx][rd_ptr[grant_idx]];
      wakeup_val   <= val_mem[grant_idx][rd_ptr[grant_idx]];
      complete_rob <= rob_mem[grant_idx][rd_ptr[grant_idx]];
      wb_src       <= grant_idx + 2'd1;
      last_grant   <= grant_idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_complete_bus_arbiter.sv
// Bench for complete_bus_arbiter: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_complete_bus_arbiter;
  localparam int DEPTH  = 2;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int ROB_W  = 6;
  localparam int OUT_W  = 1 + TAG_W + DATA_W + ROB_W + 2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
    logic [ROB_W-1:0]  rob;
  } item_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic [2:0]        fu_valid = 3'b000;
  item_t             fu_item [3];
  logic [2:0]        fu_accept;
  logic              wb_valid;
  logic [TAG_W-1:0]  wakeup_tag;
  logic [DATA_W-1:0] wakeup_val;
  logic [ROB_W-1:0]  complete_rob;
  logic [1:0]        wb_src;
  logic [OUT_W-1:0]  wb_vec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  complete_bus_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fu1_valid(fu_valid[0]), .fu1_tag(fu_item[0].tag), .fu1_val(fu_item[0].val),
    .fu1_rob(fu_item[0].rob), .fu1_accept(fu_accept[0]),
    .fu2_valid(fu_valid[1]), .fu2_tag(fu_item[1].tag), .fu2_val(fu_item[1].val),
    .fu2_rob(fu_item[1].rob), .fu2_accept(fu_accept[1]),
    .fu3_valid(fu_valid[2]), .fu3_tag(fu_item[2].tag), .fu3_val(fu_item[2].val),
    .fu3_rob(fu_item[2].rob), .fu3_accept(fu_accept[2]),
    .wb_valid(wb_valid), .wakeup_tag(wakeup_tag), .wakeup_val(wakeup_val),
    .complete_rob(complete_rob), .wb_src(wb_src)
  );

  assign wb_vec = {wb_valid, wakeup_tag, wakeup_val, complete_rob, wb_src};

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [OUT_W-1:0] mk(input int tag, input logic [31:0] val, input int rob, input int src);
    return {1'b1, TAG_W'(tag), DATA_W'(val), ROB_W'(rob), 2'(src)};
  endfunction

  function automatic item_t mk_item(input int tag, input logic [31:0] val, input int rob);
    item_t it;
    it.tag = TAG_W'(tag);
    it.val = val;
    it.rob = ROB_W'(rob);
    return it;
  endfunction

  // Reference model: one queue per FU, round-robin pointer, expected broadcast.
  item_t            mq [3][$];
  logic [OUT_W-1:0] exp_out = '0;
  int               m_last = 3;
  bit               model_ok = 1'b0;

  always @(posedge clk) begin
    bit    acc [3];
    int    win;
    int    c;
    item_t e;
    if (reset) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      m_last   = 3;
      exp_out  = '0;
      model_ok = 1'b1;
    end else if (flush) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      exp_out = '0;
    end else begin
      for (int i = 0; i < 3; i++) acc[i] = (mq[i].size() < DEPTH);
      win = -1;
      for (int k = 0; k < 3; k++) begin
        c = (m_last + k) % 3;
        if (win < 0 && mq[c].size() > 0) win = c;
      end
      if (win >= 0) begin
        e       = mq[win].pop_front();
        exp_out = {1'b1, e.tag, e.val, e.rob, 2'(win + 1)};
        m_last  = win + 1;
      end else begin
        exp_out = '0;
      end
      for (int i = 0; i < 3; i++)
        if (fu_valid[i] && acc[i]) mq[i].push_back(fu_item[i]);
    end
  end

  always @(negedge clk) begin
    logic [2:0] exp_acc;
    if (model_ok) begin
      for (int i = 0; i < 3; i++) exp_acc[i] = (mq[i].size() != DEPTH);
      check("model_wb", 64'(wb_vec), 64'(exp_out));
      check("model_accept", 64'(fu_accept), 64'(exp_acc));
    end
  end

  // Driver: each FU presents the head of its source queue and holds it until accepted.
  item_t src_q [3][$];
  bit    last_acc [3];
  bit    rand_mode = 1'b0;

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (fu_valid[i] && last_acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (fu_valid[i] && !last_acc[i]) begin
        fu_valid[i] = 1'b1;
      end else if (src_q[i].size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
        fu_valid[i] = 1'b1;
        fu_item[i]  = src_q[i][0];
      end else begin
        fu_valid[i] = 1'b0;
      end
      last_acc[i] = fu_accept[i];
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic stop_sources();
    for (int i = 0; i < 3; i++) begin
      src_q[i].delete();
      fu_valid[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic wait_wb(input string name, input int budget);
    int n = 0;
    while (!wb_valid && n < budget) begin
      tick();
      n++;
    end
    if (!wb_valid) check(name, 64'(wb_valid), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    item_t   bp_got [$];
    bit      saw_drop;
    for (int i = 0; i < 3; i++) begin
      fu_item[i]  = '0;
      last_acc[i] = 1'b0;
    end

    do_reset();
    check("reset_out", 64'(wb_vec), 64'd0);
    check("reset_accept", 64'(fu_accept), 64'h7);

    // Single result from FU2
    src_q[1].push_back(mk_item(5, 32'hDEADBEEF, 9));
    ticks(3);
    check("single_bcast", 64'(wb_vec), 64'(mk(5, 32'hDEADBEEF, 9, 2)));
    tick();
    check("single_idle", 64'(wb_vec), 64'd0);

    // Three-way collision from a fresh reset
    do_reset();
    for (int i = 0; i < 3; i++) src_q[i].push_back(mk_item(i + 1, 100 + i, i + 1));
    ticks(3);
    for (int j = 0; j < 3; j++) begin
      check("collision", 64'(wb_vec), 64'(mk(j + 1, 100 + j, j + 1, j + 1)));
      tick();
    end

    // Round-robin fairness between FU1 and FU3
    for (int i = 0; i < 6; i++) begin
      src_q[0].push_back(mk_item(10 + i, 32'h1000 + i, i));
      src_q[2].push_back(mk_item(30 + i, 32'h3000 + i, 20 + i));
    end
    wait_wb("rr_start", 10);
    for (int j = 0; j < 12; j++) begin
      if (j % 2 == 0) check("rr_order", 64'({wb_src, wakeup_tag}), 64'({2'd1, TAG_W'(10 + j / 2)}));
      else            check("rr_order", 64'({wb_src, wakeup_tag}), 64'({2'd3, TAG_W'(30 + j / 2)}));
      tick();
    end
    ticks(2);

    // Backpressure on FU1 while FU2/FU3 stream
    for (int i = 0; i < 4; i++) src_q[0].push_back(mk_item(40 + i, i, i));
    for (int i = 0; i < 10; i++) begin
      src_q[1].push_back(mk_item(50 + i, 32'h5000 + i, i));
      src_q[2].push_back(mk_item(20 + i, 32'h2000 + i, i));
    end
    saw_drop = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (!fu_accept[0]) saw_drop = 1'b1;
      if (wb_valid && wb_src == 2'd1) bp_got.push_back(mk_item(int'(wakeup_tag), wakeup_val, int'(complete_rob)));
    end
    check("bp_accept_drop", 64'(saw_drop), 64'd1);
    check("bp_count", 64'(bp_got.size()), 64'd4);
    for (int k = 0; k < bp_got.size() && k < 4; k++)
      check("bp_fu1_order", 64'(bp_got[k].tag), 64'(40 + k));

    // Tag-0 completion from FU3
    src_q[2].push_back(mk_item(0, 32'h1234, 17));
    ticks(3);
    check("tag0_bcast", 64'(wb_vec), 64'(mk(0, 32'h1234, 17, 3)));
    tick();

    // Flush mid-stream
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++) src_q[i].push_back(mk_item(1 + i * 8 + j, j, j));
    ticks(4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    stop_sources();
    check("flush_out", 64'(wb_vec), 64'd0);
    check("flush_accept", 64'(fu_accept), 64'h7);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("flush_no_stale", 64'(wb_vec), 64'd0);
    end

    // Reset mid-stream, then FU1 must win first
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++) src_q[i].push_back(mk_item(33 + i * 8 + j, j, j));
    ticks(5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stop_sources();
    check("rst_mid_out", 64'(wb_vec), 64'd0);
    check("rst_mid_accept", 64'(fu_accept), 64'h7);
    tick();
    check("rst_no_stale", 64'(wb_vec), 64'd0);
    for (int i = 0; i < 3; i++) src_q[i].push_back(mk_item(7 + i, 32'h7000 + i, 7 + i));
    ticks(3);
    check("rst_first_grant", 64'(wb_vec), 64'(mk(7, 32'h7000, 7, 1)));
    ticks(4);

    // Randomized traffic with occasional flush/reset
    rand_mode = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 3; i++)
        if (src_q[i].size() < 4 && $urandom_range(0, 2) == 0)
          src_q[i].push_back(mk_item($urandom_range(0, 63), $urandom, $urandom_range(0, 63)));
      if ($urandom_range(0, 149) == 0) flush = 1'b1;
      if ($urandom_range(0, 499) == 0) reset = 1'b1;
      tick();
      flush = 1'b0;
      reset = 1'b0;
    end
    rand_mode = 1'b0;
    ticks(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
